ps2_keyboard_rx: RTL and testbench
==================================

PS2_KEYBOARD_RX -- requirements
Module: ps2_keyboard_rx

Interface
REQ-001 SHALL have parameter FILTER, default 4: consecutive equal synchronized PS2_CLK samples required before the filtered clock changes.
REQ-002 SHALL have parameter PARITY_ODD, default 1: 1 = odd parity required, 0 = even parity required.
REQ-003 SHALL have parameter TIMEOUT, default 200000: CLK cycles allowed between falling edges inside one frame.
REQ-004 SHALL have port CLK, input, 1, the single system clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port RESET, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port PS2_CLK, input, 1, raw keyboard clock, asynchronous to CLK.
REQ-007 SHALL have port PS2_DATA, input, 1, raw keyboard data, asynchronous to CLK.
REQ-008 SHALL have port SCANCODE, output, 8, last non-prefix scancode received.
REQ-009 SHALL have port KEY_VALID, output, 1, one-cycle strobe marking a new SCANCODE.
REQ-010 SHALL have port KEY_BREAK, output, 1, SCANCODE was preceded by an F0 prefix (key release).
REQ-011 SHALL have port KEY_EXTENDED, output, 1, SCANCODE was preceded by an E0 prefix.
REQ-012 SHALL have port FRAME_ERROR, output, 1, one-cycle strobe on any discarded frame.

Function
REQ-013 SHALL pass PS2_CLK and PS2_DATA through two flip-flop synchronizers each.
REQ-014 SHALL change the filtered clock only after FILTER consecutive equal synchronized samples; a pulse shorter than FILTER cycles is ignored.
REQ-015 SHALL sample synchronized PS2_DATA in the cycle the filtered clock's falling edge is detected.
REQ-016 SHALL implement states IDLE, DATA, PARITY and STOP.
REQ-017 IDLE: on a falling edge with data 0 (start bit), go to DATA with bit counter 0; with data 1, stay in IDLE and raise no error.
REQ-018 DATA: shift 8 bits LSB first; after bit 7, go to PARITY.
REQ-019 PARITY: store the bit and go to STOP.
REQ-020 STOP: the frame is good when the stop bit is 1 and the parity check passes (XOR of data and parity = PARITY_ODD); always return to IDLE.
REQ-021 A good byte F0 SHALL set a break-pending flag and produce no KEY_VALID.
REQ-022 A good byte E0 SHALL set an extended-pending flag and produce no KEY_VALID.
REQ-023 Any other good byte SHALL load SCANCODE, load KEY_BREAK and KEY_EXTENDED from the pending flags, pulse KEY_VALID, and clear both pending flags.
REQ-024 KEY_VALID SHALL pulse exactly one cycle, 3+FILTER CLK cycles after the raw PS2_CLK falling edge of the stop bit.
REQ-025 SCANCODE, KEY_BREAK and KEY_EXTENDED SHALL hold their values until the next KEY_VALID.
REQ-026 A bad parity or bad stop bit SHALL pulse FRAME_ERROR for one cycle, discard the byte and clear both pending flags.
REQ-027 In DATA, PARITY or STOP, TIMEOUT cycles without a falling edge SHALL force IDLE, pulse FRAME_ERROR and clear both pending flags.
REQ-028 The timeout counter SHALL reset on every falling edge and saturate, never wrapping.
REQ-029 A sequence F0 E0 xx SHALL set both KEY_BREAK and KEY_EXTENDED, because the pending flags are order-independent.

Reset
REQ-030 RESET SHALL asynchronously force state IDLE and clear the bit counter, shift register, pending flags and timeout counter.
REQ-031 RESET SHALL clear SCANCODE to 00 and KEY_VALID, KEY_BREAK, KEY_EXTENDED and FRAME_ERROR to 0.
REQ-032 RESET SHALL set the synchronizer and filter state to 1 (idle-high bus).
REQ-033 A frame interrupted by RESET SHALL be discarded silently; the next start bit begins a fresh frame.

Structure
REQ-034 Package ps2_pkg SHALL hold the state encoding and the constants F0 (break prefix) and E0 (extended prefix).
REQ-035 The synchronizer and glitch filter SHALL be the sub-module ps2_sync_filter; it outputs the filtered clock, the synchronized data and a one-cycle falling-edge strobe.

Verification
REQ-036 Send frame 1C with odd parity -> KEY_VALID once, SCANCODE=1C, KEY_BREAK=0, KEY_EXTENDED=0.
REQ-037 Send F0 then 1C -> exactly one KEY_VALID, SCANCODE=1C, KEY_BREAK=1; the next frame 1C gives KEY_BREAK=0.
REQ-038 Send E0, F0, 75 -> one KEY_VALID, SCANCODE=75, KEY_BREAK=1, KEY_EXTENDED=1.
REQ-039 Send 5A with wrong parity (PARITY_ODD=1) -> FRAME_ERROR one cycle, no KEY_VALID, SCANCODE unchanged; repeat with PARITY_ODD=0 and even parity -> accepted.
REQ-040 Stall after 5 data bits for TIMEOUT+10 cycles -> FRAME_ERROR once, state IDLE; the following 5A frame is received correctly.
REQ-041 Inject a 2-cycle low glitch on PS2_CLK mid-bit and assert RESET mid-frame -> no extra bit shifted; after reset all outputs are zero and the next 29 frame yields SCANCODE=29.

Source files
------------

// File: rtl/ps2_keyboard_rx_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver: frame FSM
// encoding, scancode prefixes and the debug view of the receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_t;

    localparam logic [7:0] BREAK_PREFIX    = 8'hF0;
    localparam logic [7:0] EXTENDED_PREFIX = 8'hE0;

    typedef struct packed {
        ps2_state_t state;
        logic       clk_filt;
        logic [2:0] bit_cnt;
    } ps2_dbg_t;

    // A frame is good when the stop bit is high and the data+parity ones count
    // has the configured polarity (1 = odd, 0 = even).
    function automatic logic frame_ok(input logic [7:0] data,
                                      input logic       parity,
                                      input logic       stop,
                                      input logic       odd);
        return stop && ((^data ^ parity) == odd);
    endfunction

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// Link between the PS/2 line conditioner and the frame receiver.
interface ps2_keyboard_rx_if;

    // clk_fall is a one-cycle strobe, no back-pressure: the receiver must act
    // on data_sync in the same cycle clk_fall is high or the bit is lost.
    logic clk_filt;
    logic data_sync;
    logic clk_fall;

    modport master (
        output clk_filt,
        output data_sync,
        output clk_fall
    );

    modport slave (
        input clk_filt,
        input data_sync,
        input clk_fall
    );

endinterface

// File: rtl/ps2_keyboard_rx_sync_filter.sv
// Two-stage synchronizers for PS2_CLK/PS2_DATA plus a glitch filter on the
// clock that produces a one-cycle falling-edge strobe.
module ps2_sync_filter #(
    parameter int FILTER = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    ps2_keyboard_rx_if.master link
);

    localparam int CW = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER - 1);

    logic [1:0]    clk_meta;
    logic [1:0]    data_meta;
    logic          clk_sync;
    logic          filt;
    logic [CW-1:0] cnt;
    logic          fall;

    // The bus idles high, so everything resets to 1 to avoid a false edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_meta  <= 2'b11;
            data_meta <= 2'b11;
        end else begin
            clk_meta  <= {clk_meta[0], ps2_clk};
            data_meta <= {data_meta[0], ps2_data};
        end
    end

    assign clk_sync = clk_meta[1];

    // The filtered clock follows only after FILTER consecutive samples that
    // disagree with it; any agreeing sample restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt <= 1'b1;
            cnt  <= '0;
            fall <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_sync == filt) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                filt <= clk_sync;
                cnt  <= '0;
                fall <= filt;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign link.clk_filt  = filt;
    assign link.data_sync = data_meta[1];
    assign link.clk_fall  = fall;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: frames 11-bit PS/2 words, checks parity and stop,
// folds F0/E0 prefixes into break/extended flags and reports scancodes.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FILTER     = 4,
    parameter bit PARITY_ODD = 1'b1,
    parameter int TIMEOUT    = 200000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [7:0] SCANCODE,
    output logic       KEY_VALID,
    output logic       KEY_BREAK,
    output logic       KEY_EXTENDED,
    output logic       FRAME_ERROR,
    output ps2_dbg_t   DEBUG
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

    ps2_keyboard_rx_if link ();

    ps2_sync_filter #(
        .FILTER (FILTER)
    ) u_sync_filter (
        .clk      (CLK),
        .rst      (RESET),
        .ps2_clk  (PS2_CLK),
        .ps2_data (PS2_DATA),
        .link     (link.master)
    );

    ps2_state_t state;
    ps2_state_t state_next;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          parity_bit;
    logic [TW-1:0] tmo_cnt;
    logic          brk_pend;
    logic          ext_pend;
    logic          fall;
    logic          din;
    logic          timeout_hit;
    logic          frame_done;
    logic          frame_good;

    assign fall = link.clk_fall;
    assign din  = link.data_sync;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        timeout_hit = 1'b0;
        frame_done  = 1'b0;
        case (state)
            IDLE:    if (fall && !din) state_next = DATA;
            DATA:    if (fall && bit_cnt == 3'd7) state_next = PARITY;
            PARITY:  if (fall) state_next = STOP;
            STOP: begin
                if (fall) begin
                    state_next = IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        // A stalled frame is abandoned once the saturated counter is reached.
        if (state != IDLE && !fall && tmo_cnt == TMO_MAX) begin
            state_next  = IDLE;
            timeout_hit = 1'b1;
        end
    end

    // In STOP the sampled line value is the stop bit itself.
    assign frame_good = frame_ok(shift, parity_bit, din, PARITY_ODD);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            bit_cnt      <= '0;
            shift        <= '0;
            parity_bit   <= 1'b0;
            tmo_cnt      <= '0;
            brk_pend     <= 1'b0;
            ext_pend     <= 1'b0;
            SCANCODE     <= '0;
            KEY_VALID    <= 1'b0;
            KEY_BREAK    <= 1'b0;
            KEY_EXTENDED <= 1'b0;
            FRAME_ERROR  <= 1'b0;
        end else begin
            KEY_VALID   <= 1'b0;
            FRAME_ERROR <= 1'b0;

            if (state == IDLE || fall) begin
                tmo_cnt <= '0;
            end else if (tmo_cnt != TMO_MAX) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            if (fall) begin
                case (state)
                    IDLE:    bit_cnt <= '0;
                    DATA: begin
                        shift   <= {din, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    PARITY:  parity_bit <= din;
                    default: ;
                endcase
            end

            if (timeout_hit) begin
                FRAME_ERROR <= 1'b1;
                brk_pend    <= 1'b0;
                ext_pend    <= 1'b0;
            end else if (frame_done) begin
                if (!frame_good) begin
                    FRAME_ERROR <= 1'b1;
                    brk_pend    <= 1'b0;
                    ext_pend    <= 1'b0;
                end else if (shift == BREAK_PREFIX) begin
                    brk_pend <= 1'b1;
                end else if (shift == EXTENDED_PREFIX) begin
                    ext_pend <= 1'b1;
                end else begin
                    SCANCODE     <= shift;
                    KEY_BREAK    <= brk_pend;
                    KEY_EXTENDED <= ext_pend;
                    KEY_VALID    <= 1'b1;
                    brk_pend     <= 1'b0;
                    ext_pend     <= 1'b0;
                end
            end
        end
    end

    assign DEBUG = {state, link.clk_filt, bit_cnt};

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: table of frames with expected key events, a
// scoreboard queue popped by a monitor, and hand-written corner sequences.
module tb_ps2_keyboard_rx;
    import ps2_pkg::*;

    localparam int FILTER  = 4;
    localparam int TIMEOUT = 400;
    localparam int HALF    = 20;
    localparam int W       = 11;
    localparam int NV      = 16;

    typedef struct {
        logic [7:0]   code;
        logic         bad_par;
        logic         bad_stop;
        logic         has_evt;
        logic [W-1:0] evt;
    } vec_t;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic ps2_clk  = 1'b1;
    logic ps2_data = 1'b1;
    logic uf_clk   = 1'b1;

    logic [7:0] scancode;
    logic       key_valid, key_break, key_extended, frame_error;
    ps2_dbg_t   dbg;
    logic [7:0] ev_scancode;
    logic       ev_valid, ev_break, ev_extended, ev_err;
    ps2_dbg_t   ev_dbg;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int stop_cyc = 0;
    int ev_cnt = 0;
    int ev_err_cnt = 0;
    int uf_falls = 0;
    logic [7:0] ev_code = '0;
    logic prev_kv = 1'b0;
    logic prev_fe = 1'b0;
    logic [W-1:0] mon_e;
    logic [W-1:0] exp_q[$];
    vec_t vecs[NV];

    ps2_keyboard_rx #(.FILTER(FILTER), .PARITY_ODD(1'b1), .TIMEOUT(TIMEOUT)) dut (
        .CLK(clk), .RESET(rst), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data),
        .SCANCODE(scancode), .KEY_VALID(key_valid), .KEY_BREAK(key_break),
        .KEY_EXTENDED(key_extended), .FRAME_ERROR(frame_error), .DEBUG(dbg)
    );

    ps2_keyboard_rx #(.FILTER(FILTER), .PARITY_ODD(1'b0), .TIMEOUT(TIMEOUT)) dut_even (
        .CLK(clk), .RESET(rst), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data),
        .SCANCODE(ev_scancode), .KEY_VALID(ev_valid), .KEY_BREAK(ev_break),
        .KEY_EXTENDED(ev_extended), .FRAME_ERROR(ev_err), .DEBUG(ev_dbg)
    );

    ps2_keyboard_rx_if u_link ();

    ps2_sync_filter #(.FILTER(FILTER)) u_filt (
        .clk(clk), .rst(rst), .ps2_clk(uf_clk), .ps2_data(1'b1), .link(u_link.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] mk(input logic e, input logic b, input logic x,
                                        input logic [7:0] c);
        return {e, b, x, c};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_kv = 1'b0;
            prev_fe = 1'b0;
        end else begin
            if (key_valid || frame_error) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event actual=%0h expected=none",
                             {frame_error, key_break, key_extended, scancode});
                end else begin
                    mon_e = exp_q.pop_front();
                    if (key_valid) begin
                        check("key_event", {1'b0, key_break, key_extended, scancode}, mon_e);
                        check("valid_latency", cyc - stop_cyc, 3 + FILTER);
                    end else begin
                        check("error_event", {frame_error, 10'h000}, mon_e);
                    end
                end
            end
            if (key_valid) check("valid_pulse_width", prev_kv, 0);
            if (frame_error) check("error_pulse_width", prev_fe, 0);
            prev_kv = key_valid;
            prev_fe = frame_error;
            if (ev_valid) begin
                ev_cnt++;
                ev_code = ev_scancode;
            end
            if (ev_err) ev_err_cnt++;
            if (u_link.clk_fall) uf_falls++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic set_clk(input logic v);
        @(posedge clk);
        #1;
        ps2_clk = v;
    endtask

    task automatic drive_bit(input logic b, input logic glitch, input logic is_stop);
        ps2_data = b;
        if (glitch) begin
            tick(HALF / 2);
            set_clk(1'b0);
            tick(1);
            set_clk(1'b1);
            tick(HALF / 2);
        end else begin
            tick(HALF);
        end
        set_clk(1'b0);
        if (is_stop) stop_cyc = cyc;
        tick(HALF);
        set_clk(1'b1);
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] code, input logic bad_par,
                                               input logic bad_stop);
        return {1'b1 ^ bad_stop, (~^code) ^ bad_par, code, 1'b0};
    endfunction

    task automatic send_frame(input logic [7:0] code, input logic bad_par,
                              input logic bad_stop, input int glitch_bit);
        logic [10:0] bits;
        bits = frame_bits(code, bad_par, bad_stop);
        for (int i = 0; i < 11; i++) drive_bit(bits[i], i == glitch_bit, i == 10);
        ps2_data = 1'b1;
        tick(3 * HALF);
    endtask

    task automatic send_partial(input logic [7:0] code, input int ndata);
        logic [10:0] bits;
        bits = frame_bits(code, 1'b0, 1'b0);
        for (int i = 0; i <= ndata; i++) drive_bit(bits[i], 1'b0, 1'b0);
        ps2_data = 1'b1;
    endtask

    task automatic uf_low(input int n);
        @(posedge clk);
        #1;
        uf_clk = 1'b0;
        repeat (n - 1) @(posedge clk);
        @(posedge clk);
        #1;
        uf_clk = 1'b1;
        tick(20);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_scancode"}, scancode, 0);
        check({tag, "_valid"}, key_valid, 0);
        check({tag, "_break"}, key_break, 0);
        check({tag, "_extended"}, key_extended, 0);
        check({tag, "_error"}, frame_error, 0);
        check({tag, "_state"}, 32'(dbg.state), 32'(IDLE));
    endtask

    initial begin
        int ev_cnt0;
        int ev_err0;
        int uf0;
        logic [7:0] rc;

        vecs[0]  = '{8'h1C, 1'b0, 1'b0, 1'b1, mk(1'b0, 1'b0, 1'b0, 8'h1C)};
        vecs[1]  = '{8'hF0, 1'b0, 1'b0, 1'b0, '0};
        vecs[2]  = '{8'h1C, 1'b0, 1'b0, 1'b1, mk(1'b0, 1'b1, 1'b0, 8'h1C)};
        vecs[3]  = '{8'h1C, 1'b0, 1'b0, 1'b1, mk(1'b0, 1'b0, 1'b0, 8'h1C)};
        vecs[4]  = '{8'hE0, 1'b0, 1'b0, 1'b0, '0};
        vecs[5]  = '{8'hF0, 1'b0, 1'b0, 1'b0, '0};
        vecs[6]  = '{8'h75, 1'b0, 1'b0, 1'b1, mk(1'b0, 1'b1, 1'b1, 8'h75)};
        vecs[7]  = '{8'hF0, 1'b0, 1'b0, 1'b0, '0};
        vecs[8]  = '{8'hE0, 1'b0, 1'b0, 1'b0, '0};
        vecs[9]  = '{8'h6B, 1'b0, 1'b0, 1'b1, mk(1'b0, 1'b1, 1'b1, 8'h6B)};
        vecs[10] = '{8'hF0, 1'b0, 1'b0, 1'b0, '0};
        vecs[11] = '{8'h5A, 1'b1, 1'b0, 1'b1, mk(1'b1, 1'b0, 1'b0, 8'h00)};
        vecs[12] = '{8'h5A, 1'b0, 1'b0, 1'b1, mk(1'b0, 1'b0, 1'b0, 8'h5A)};
        vecs[13] = '{8'hE0, 1'b0, 1'b0, 1'b0, '0};
        vecs[14] = '{8'h12, 1'b0, 1'b1, 1'b1, mk(1'b1, 1'b0, 1'b0, 8'h00)};
        vecs[15] = '{8'h34, 1'b0, 1'b0, 1'b1, mk(1'b0, 1'b0, 1'b0, 8'h34)};

        // Clock/reset
        tick(5);
        #1;
        check_outputs_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(10);
        #1;
        check_outputs_zero("post_reset");

        // Line conditioner: FILTER-1 cycle low is ignored, FILTER cycles pass
        uf0 = uf_falls;
        uf_low(FILTER - 1);
        check("filter_short_pulse", uf_falls - uf0, 0);
        check("filter_held_high", u_link.clk_filt, 1);
        uf_low(FILTER);
        check("filter_long_pulse", uf_falls - uf0, 1);
        check("filter_data_sync", u_link.data_sync, 1);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].has_evt) exp_q.push_back(vecs[i].evt);
            send_frame(vecs[i].code, vecs[i].bad_par, vecs[i].bad_stop, -1);
        end

        // Parity polarity: wrong parity for the odd receiver is right for the even one
        ev_cnt0 = ev_cnt;
        ev_err0 = ev_err_cnt;
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00));
        send_frame(8'h5A, 1'b1, 1'b0, -1);
        check("scancode_held", scancode, 8'h34);
        check("even_accept_count", ev_cnt - ev_cnt0, 1);
        check("even_scancode", ev_code, 8'h5A);
        check("even_no_error", ev_err_cnt - ev_err0, 0);

        // Timeout after 5 data bits
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00));
        send_partial(8'hA5, 5);
        tick(TIMEOUT + 10);
        #1;
        check("timeout_state_idle", 32'(dbg.state), 32'(IDLE));
        check("timeout_event_consumed", exp_q.size(), 0);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 8'h5A));
        send_frame(8'h5A, 1'b0, 1'b0, -1);

        // Glitch mid-bit must not shift an extra bit
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 8'h29));
        send_frame(8'h29, 1'b0, 1'b0, 4);
        check("glitch_scancode", scancode, 8'h29);

        // Reset mid-frame with a break prefix pending
        send_frame(8'hF0, 1'b0, 1'b0, -1);
        send_partial(8'h33, 4);
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick(3);
        #1;
        check_outputs_zero("mid_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(10);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 8'h29));
        send_frame(8'h29, 1'b0, 1'b0, -1);

        // Random plain scancodes
        for (int i = 0; i < 4; i++) begin
            do begin
                rc = 8'($urandom_range(0, 255));
            end while (rc == 8'hF0 || rc == 8'hE0);
            exp_q.push_back(mk(1'b0, 1'b0, 1'b0, rc));
            send_frame(rc, 1'b0, 1'b0, -1);
        end

        tick(50);
        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
